// File: rtl/attack_resolver.sv
// ============================================================================
// Module  : attack_resolver
// Brief   : Player-turn attack sweep, damage calculation and monster HP owner.
//           Optional critical-hit window enabled by defining ATTACK_CRIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module attack_resolver #(
    parameter int CURSOR_DIV  = 250000,
    parameter int BAR_W       = 320,
    parameter int MAX_DMG     = 40,
    parameter int HP_INIT     = 200,
    parameter int SHOW_CYCLES = 50000000,
    parameter int CRIT_WIN    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] game_state,
    input  logic       btn,
    output logic       attack,
    output logic [9:0] cursor_x,
    output logic [7:0] damage,
    output logic [7:0] monster_hp,
    output logic       monster_alive,
`ifdef ATTACK_CRIT_EN
    output logic       crit,
`endif
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SWEEP = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_SHOW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int c_DIV_W  = (CURSOR_DIV > 1) ? $clog2(CURSOR_DIV) : 1;
    localparam int c_SHOW_W = $clog2(SHOW_CYCLES + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CURSOR_DIV - 1);
    localparam logic [c_SHOW_W-1:0] c_SHOW_LAST = c_SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [9:0]          c_CENTRE    = 10'(BAR_W / 2);
    localparam logic [9:0]          c_LAST_POS  = 10'(BAR_W - 1);
    localparam logic [9:0]          c_MAX_DMG   = 10'(MAX_DMG);
    localparam logic [7:0]          c_HP_INIT   = 8'(HP_INIT);

    // Elaboration-time guard on parameter ranges
    if (BAR_W > 1024 || BAR_W < 2 || MAX_DMG > 255 || HP_INIT < 1 || HP_INIT > 255 ||
        SHOW_CYCLES < 1 || CURSOR_DIV < 1 || CRIT_WIN < 0) begin : g_bad_params
        $error("attack_resolver: parameter out of range");
    end

    logic [2:0]          r_state;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_SHOW_W-1:0] r_show;
    logic [9:0]          r_cursor;
    logic [9:0]          r_pos;
    logic                r_miss;
    logic [7:0]          r_dmg;
    logic [7:0]          r_hp;
    logic                r_attack;
    logic                r_btn_s1;
    logic                r_btn_s2;
    logic                r_btn_prev;
    logic [1:0]          r_gs_prev;

    logic [1:0] w_gs;
    logic       w_turn;
    logic       w_reload;
    logic       w_press;
    logic [9:0] w_dist;
    logic [7:0] w_lin_dmg;
    logic [7:0] w_dmg;
    logic [7:0] w_hp_next;

    assign w_gs     = (game_state == 2'd3) ? 2'd0 : game_state;
    assign w_turn   = (w_gs == 2'd1);
    assign w_reload = (r_gs_prev == 2'd2) && (w_gs != 2'd2);
    assign w_press  = r_btn_s2 & ~r_btn_prev;

    assign w_dist    = (r_pos >= c_CENTRE) ? (r_pos - c_CENTRE) : (c_CENTRE - r_pos);
    assign w_lin_dmg = (w_dist < c_MAX_DMG) ? 8'(c_MAX_DMG - w_dist) : 8'd0;
    assign w_hp_next = (r_hp >= r_dmg) ? (r_hp - r_dmg) : 8'd0;

`ifdef ATTACK_CRIT_EN
    logic        w_crit_hit;
    logic [10:0] w_dbl;
    logic        r_crit_hit;
    logic        r_crit;

    assign w_crit_hit = (w_dist <= 10'(CRIT_WIN)) && (w_dist < c_MAX_DMG) && !r_miss;
    assign w_dbl      = {1'b0, c_MAX_DMG - w_dist} << 1;
    assign w_dmg      = r_miss ? 8'd0 :
                        w_crit_hit ? ((w_dbl > 11'd255) ? 8'd255 : w_dbl[7:0]) : w_lin_dmg;
    assign crit       = r_crit;
`else
    assign w_dmg = r_miss ? 8'd0 : w_lin_dmg;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_btn_prev <= 1'b0;
            r_gs_prev  <= 2'd0;
        end else begin
            r_btn_s1   <= btn;
            r_btn_s2   <= r_btn_s1;
            r_btn_prev <= r_btn_s2;
            r_gs_prev  <= w_gs;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_show   <= '0;
            r_cursor <= 10'd0;
            r_pos    <= 10'd0;
            r_miss   <= 1'b0;
            r_dmg    <= 8'd0;
            r_hp     <= c_HP_INIT;
            r_attack <= 1'b0;
`ifdef ATTACK_CRIT_EN
            r_crit_hit <= 1'b0;
            r_crit     <= 1'b0;
`endif
        end else begin
            r_attack <= 1'b0;
`ifdef ATTACK_CRIT_EN
            r_crit   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_turn) begin
                        r_state  <= S_SWEEP;
                        r_cursor <= 10'd0;
                        r_div    <= '0;
                    end
                end
                S_SWEEP: begin
                    // Press wins over a coincident step, so the pre-step position is kept
                    if (!w_turn) begin
                        r_state <= S_IDLE;
                    end else if (w_press) begin
                        r_pos   <= r_cursor;
                        r_miss  <= 1'b0;
                        r_state <= S_CALC;
                    end else if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (r_cursor == c_LAST_POS) begin
                            r_pos   <= r_cursor;
                            r_miss  <= 1'b1;
                            r_state <= S_CALC;
                        end else begin
                            r_cursor <= r_cursor + 10'd1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                S_CALC: begin
                    if (!w_turn) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_dmg   <= w_dmg;
                        r_show  <= '0;
                        r_state <= S_SHOW;
`ifdef ATTACK_CRIT_EN
                        r_crit_hit <= w_crit_hit;
`endif
                    end
                end
                S_SHOW: begin
                    if (!w_turn) begin
                        r_state <= S_IDLE;
                    end else if (r_show == c_SHOW_LAST) begin
                        r_hp     <= w_hp_next;
                        r_attack <= 1'b1;
                        r_state  <= S_DONE;
`ifdef ATTACK_CRIT_EN
                        r_crit   <= r_crit_hit;
`endif
                    end else begin
                        r_show <= r_show + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!w_turn) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Leaving the end/menu state starts a new game
            if (w_reload) begin
                r_hp  <= c_HP_INIT;
                r_dmg <= 8'd0;
            end
        end
    end

    assign attack        = r_attack;
    assign cursor_x      = r_cursor;
    assign damage        = r_dmg;
    assign monster_hp    = r_hp;
    assign monster_alive = (r_hp != 8'd0);
    assign busy          = (r_state == S_SWEEP) || (r_state == S_SHOW);

endmodule

`default_nettype wire

// File: tb/tb_attack_resolver.sv
// ============================================================================
// Module  : tb_attack_resolver
// Brief   : Directed vector bench for attack_resolver (default build, no crit).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_attack_resolver;

    localparam int CURSOR_DIV  = 2;
    localparam int BAR_W       = 16;
    localparam int MAX_DMG     = 8;
    localparam int HP_INIT     = 20;
    localparam int SHOW_CYCLES = 4;
    localparam int CRIT_WIN    = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] gs;
    logic       btn;
    logic       attack;
    logic [9:0] cursor_x;
    logic [7:0] damage;
    logic [7:0] monster_hp;
    logic       monster_alive;
    logic       busy;

    attack_resolver #(
        .CURSOR_DIV (CURSOR_DIV),
        .BAR_W      (BAR_W),
        .MAX_DMG    (MAX_DMG),
        .HP_INIT    (HP_INIT),
        .SHOW_CYCLES(SHOW_CYCLES),
        .CRIT_WIN   (CRIT_WIN)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .game_state   (gs),
        .btn          (btn),
        .attack       (attack),
        .cursor_x     (cursor_x),
        .damage       (damage),
        .monster_hp   (monster_hp),
        .monster_alive(monster_alive),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit reload;
        int pos;       // -1: no press
        bit hold;      // button held high from before the turn starts
        int exp_dmg;
        int exp_hp;
        int exp_alive;
    } vec_t;

    vec_t vecs[11];

    // One player turn; all observations on negedges, k counts negedges after gs=1
    task automatic run_turn(input int p, output int atk_k, output int atk_cnt,
                            output int dmg_at, output int hp_pre, output int hp_at,
                            output int alive_at);
        int tgt;
        tgt      = (p < 0) ? 38 : 2 * p + 8;
        atk_k    = -1;
        atk_cnt  = 0;
        dmg_at   = -1;
        hp_pre   = -1;
        hp_at    = -1;
        alive_at = -1;
        gs = 2'd1;
        if (p == 0) btn = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (attack) begin
                atk_cnt++;
                if (atk_k < 0) atk_k = k;
            end
            if (k == tgt - 4) dmg_at = int'(damage);
            if (k == tgt - 1) hp_pre = int'(monster_hp);
            if (k == tgt) begin
                hp_at    = int'(monster_hp);
                alive_at = int'(monster_alive);
            end
            if (p > 0 && k == 2 * p) btn = 1'b1;
            if (p >= 0 && k == 2 * p + 5) btn = 1'b0;
        end
        gs  = 2'd0;
        btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int atk_k, atk_cnt, dmg_at, hp_pre, hp_at, alive_at, tgt, prev_hp, cnt;

        vecs = '{
            '{1'b0,  8, 1'b0, 8, 12, 1},
            '{1'b1,  3, 1'b0, 3, 17, 1},
            '{1'b0,  0, 1'b0, 0, 17, 1},
            '{1'b0, 15, 1'b0, 1, 16, 1},
            '{1'b0, 10, 1'b0, 6, 10, 1},
            '{1'b0, -1, 1'b0, 0, 10, 1},
            '{1'b0, -1, 1'b1, 0, 10, 1},
            '{1'b1,  8, 1'b0, 8, 12, 1},
            '{1'b0,  8, 1'b0, 8,  4, 1},
            '{1'b0,  8, 1'b0, 8,  0, 0},
            '{1'b1,  9, 1'b0, 7, 13, 1}
        };

        rst_n = 1'b0;
        gs    = 2'd0;
        btn   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_attack", int'(attack), 0);
        chk("reset_cursor", int'(cursor_x), 0);
        chk("reset_damage", int'(damage), 0);
        chk("reset_hp", int'(monster_hp), HP_INIT);
        chk("reset_alive", int'(monster_alive), 1);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        prev_hp = HP_INIT;

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].reload) begin
                gs = 2'd2;
                repeat (2) @(negedge clk);
                gs = 2'd0;
                repeat (2) @(negedge clk);
                chk($sformatf("v%0d_reload_hp", i), int'(monster_hp), HP_INIT);
                chk($sformatf("v%0d_reload_dmg", i), int'(damage), 0);
                chk($sformatf("v%0d_reload_alive", i), int'(monster_alive), 1);
                prev_hp = HP_INIT;
            end
            if (vecs[i].hold) begin
                btn = 1'b1;
                repeat (4) @(negedge clk);
            end
            tgt = (vecs[i].pos < 0) ? 38 : 2 * vecs[i].pos + 8;
            run_turn(vecs[i].pos, atk_k, atk_cnt, dmg_at, hp_pre, hp_at, alive_at);
            chk($sformatf("v%0d_attack_count", i), atk_cnt, 1);
            chk($sformatf("v%0d_attack_cycle", i), atk_k, tgt);
            chk($sformatf("v%0d_damage_early", i), dmg_at, vecs[i].exp_dmg);
            chk($sformatf("v%0d_hp_before", i), hp_pre, prev_hp);
            chk($sformatf("v%0d_hp_at_attack", i), hp_at, vecs[i].exp_hp);
            chk($sformatf("v%0d_alive_at_attack", i), alive_at, vecs[i].exp_alive);
            chk($sformatf("v%0d_damage_after", i), int'(damage), vecs[i].exp_dmg);
            chk($sformatf("v%0d_busy_after", i), int'(busy), 0);
            prev_hp = vecs[i].exp_hp;
        end

        // Abort in the very cycle of the final SHOW count: abort must win
        cnt = 0;
        gs  = 2'd1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (attack) cnt++;
            if (k == 20) chk("abort_damage_valid", int'(damage), 8);
            if (k == 22) chk("abort_busy_in_show", int'(busy), 1);
            if (k == 16) btn = 1'b1;
            if (k == 21) btn = 1'b0;
            if (k == 23) gs = 2'd0;
        end
        chk("abort_no_attack", cnt, 0);
        chk("abort_damage_kept", int'(damage), 8);
        chk("abort_hp_kept", int'(monster_hp), prev_hp);
        chk("abort_busy", int'(busy), 0);

        // Asynchronous reset in the middle of a sweep
        gs = 2'd1;
        repeat (5) @(negedge clk);
        chk("rst_pre_busy", int'(busy), 1);
        chk("rst_pre_cursor", int'(cursor_x), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_attack", int'(attack), 0);
        chk("rst_async_cursor", int'(cursor_x), 0);
        chk("rst_async_damage", int'(damage), 0);
        chk("rst_async_hp", int'(monster_hp), HP_INIT);
        chk("rst_async_alive", int'(monster_alive), 1);
        chk("rst_async_busy", int'(busy), 0);
        gs = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_release_hp", int'(monster_hp), HP_INIT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
